acq_sequencer: RTL and testbench

Acquisition controller for the oscilloscope capture path. It sits between the sample-rate divider, the trigger control block and the storage memory. It sequences pre-trigger fill, arming, post-trigger capture and display holdoff. It generates the memory write strobe and address, re-arms the trigger logic, and publishes the read base address so the VGA side draws a stable, trigger-aligned trace.

---
 rtl/oscilloscope_pkg.sv | 35 +++
 rtl/ring_addr_counter.sv | 48 ++++
 rtl/acq_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_acq_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oscilloscope_pkg.sv
// Shared types and constants for the oscilloscope acquisition path.
// Holds the sequencer state encoding, the run-mode codes and the modulo address helper.
package oscilloscope_pkg;

  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4,
    S_HOLDOFF = 3'd5
  } acq_state_e;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;
  localparam logic [1:0] MODE_STOP   = 2'b11;

  // (addr - off) mod depth; depth need not be a power of two, so wrap explicitly.
  function automatic logic [ADDR_W-1:0] addr_sub_mod(input logic [ADDR_W-1:0] addr,
                                                     input int off, input int depth);
    int a;
    int r;
    a = int'(addr);
    if (a >= off) begin
      r = a - off;
    end else begin
      r = a + depth - off;
    end
    return ADDR_W'(r);
  endfunction

endpackage

// File: rtl/ring_addr_counter.sv
// Modulo-DEPTH address pointer with enable and synchronous clear.
// The wrap is an explicit compare so non-power-of-two depths work.
module ring_addr_counter
  import oscilloscope_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int W     = ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // next pointer: clear wins over advance
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = {W{1'b0}};
    end else if (en) begin
      if (ptr_q == LAST) begin
        ptr_d = {W{1'b0}};
      end else begin
        ptr_d = ptr_q + W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= {W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: pre-trigger fill, arming, post-trigger capture and display holdoff.
// Drives the capture memory write port and publishes the trigger-aligned read base.
module acq_sequencer
  import oscilloscope_pkg::*;
#(
  parameter int DEPTH          = 640,
  parameter int PRETRIG        = 64,
  parameter int AUTO_TIMEOUT   = 4096,
  parameter int HOLDOFF_FRAMES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              trigger,
  input  logic              frame_start,
  input  logic [1:0]        run_mode,
  input  logic              single_arm,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic              rst_trig,
  output logic [ADDR_W-1:0] rd_base,
  output logic              capture_done,
  output logic              busy
);

  localparam int POST_LEN = DEPTH - PRETRIG;
  localparam int PRE_W    = $clog2(PRETRIG + 1);
  localparam int POST_W   = $clog2(DEPTH + 1);
  localparam int TO_W     = $clog2(AUTO_TIMEOUT + 1);
  localparam int HO_W     = $clog2(HOLDOFF_FRAMES + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRETRIG - 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_LEN - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(AUTO_TIMEOUT);
  localparam logic [HO_W-1:0]   HO_LAST   = HO_W'(HOLDOFF_FRAMES - 1);

  acq_state_e        state_q, state_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [POST_W-1:0] post_cnt_q, post_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [HO_W-1:0]   ho_cnt_q, ho_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic              rst_trig_q, rst_trig_d;
  logic              capture_done_q, capture_done_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic              timeout_hit;

  ring_addr_counter #(
    .DEPTH(DEPTH),
    .W    (ADDR_W)
  ) u_wr_ptr (
    .clk(clk),
    .rst(rst),
    .clr(1'b0),
    .en (wren),
    .ptr(wr_ptr)
  );

  assign wren = sample_tick &&
                ((state_q == S_PRETRIG) || (state_q == S_ARMED) || (state_q == S_CAPTURE));
  assign wraddress   = wr_ptr;
  assign timeout_hit = (run_mode == MODE_AUTO) && (to_cnt_q == TO_MAX);

  // next state, phase counters and registered output values
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = {PRE_W{1'b0}};
    post_cnt_d  = {POST_W{1'b0}};
    to_cnt_d    = {TO_W{1'b0}};
    ho_cnt_d    = {HO_W{1'b0}};
    trig_addr_d = trig_addr_q;
    case (state_q)
      S_IDLE: begin
        if ((run_mode == MODE_NORMAL) || (run_mode == MODE_AUTO)) begin
          state_d = S_PRETRIG;
        end else if ((run_mode == MODE_SINGLE) && single_arm) begin
          state_d = S_PRETRIG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRETRIG: begin
        if (run_mode == MODE_STOP) begin
          state_d = S_IDLE;
        end else if (sample_tick) begin
          if (pre_cnt_q == PRE_LAST) begin
            state_d = S_ARMED;
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end
        end else begin
          pre_cnt_d = pre_cnt_q;
        end
      end
      S_ARMED: begin
        if (run_mode == MODE_STOP) begin
          state_d = S_IDLE;
        end else if (trigger || timeout_hit) begin
          // a tick on the trigger cycle is the first post-trigger sample
          trig_addr_d = wr_ptr;
          if (sample_tick) begin
            post_cnt_d = POST_W'(1);
            if (POST_LEN == 1) begin
              state_d = S_DONE;
            end else begin
              state_d = S_CAPTURE;
            end
          end else begin
            state_d = S_CAPTURE;
          end
        end else if ((run_mode == MODE_AUTO) && sample_tick) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end
      S_CAPTURE: begin
        if (sample_tick) begin
          if (post_cnt_q == POST_LAST) begin
            state_d = S_DONE;
          end else begin
            post_cnt_d = post_cnt_q + POST_W'(1);
          end
        end else begin
          post_cnt_d = post_cnt_q;
        end
      end
      S_DONE: begin
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (frame_start) begin
          if (ho_cnt_q == HO_LAST) begin
            if ((run_mode == MODE_SINGLE) || (run_mode == MODE_STOP)) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_PRETRIG;
            end
          end else begin
            ho_cnt_d = ho_cnt_q + HO_W'(1);
          end
        end else begin
          ho_cnt_d = ho_cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rst_trig_d     = (state_d == S_ARMED) && (state_q != S_ARMED);
    capture_done_d = (state_d == S_DONE);
    busy_d         = (state_d != S_IDLE);
    if (state_d == S_DONE) begin
      rd_base_d = addr_sub_mod(trig_addr_d, PRETRIG, DEPTH);
    end else begin
      rd_base_d = rd_base_q;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pre_cnt_q      <= {PRE_W{1'b0}};
      post_cnt_q     <= {POST_W{1'b0}};
      to_cnt_q       <= {TO_W{1'b0}};
      ho_cnt_q       <= {HO_W{1'b0}};
      trig_addr_q    <= {ADDR_W{1'b0}};
      rd_base_q      <= {ADDR_W{1'b0}};
      rst_trig_q     <= 1'b0;
      capture_done_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      post_cnt_q     <= post_cnt_d;
      to_cnt_q       <= to_cnt_d;
      ho_cnt_q       <= ho_cnt_d;
      trig_addr_q    <= trig_addr_d;
      rd_base_q      <= rd_base_d;
      rst_trig_q     <= rst_trig_d;
      capture_done_q <= capture_done_d;
      busy_q         <= busy_d;
    end
  end

  assign rst_trig     = rst_trig_q;
  assign rd_base      = rd_base_q;
  assign capture_done = capture_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed-plus-random bench for acq_sequencer (DEPTH=16, PRETRIG=4, AUTO_TIMEOUT=20).
// Expected addresses, write totals and read bases come from modulo arithmetic on the bench's own pointer.
module tb_acq_sequencer;

  localparam int D   = 16;
  localparam int PRE = 4;
  localparam int TO  = 20;

  logic       clk;
  logic       rst;
  logic       sample_tick;
  logic       trigger;
  logic       frame_start;
  logic [1:0] run_mode;
  logic       single_arm;
  logic       wren;
  logic [9:0] wraddress;
  logic       rst_trig;
  logic [9:0] rd_base;
  logic       capture_done;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_no = 0;
  int model_ptr = 0;
  int writes = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int rst_trig_cnt = 0;
  int prev_wa = -1;
  int first_wa = -1;
  int fr_ph = 0;
  int exp_rd_last = 0;
  int p0 = 0;
  int k = 0;
  int w0 = 0;
  int d0 = 0;
  bit tick_ph = 1'b0;
  bit done_now = 1'b0;
  bit wrap_seen = 1'b0;

  acq_sequencer #(
    .DEPTH         (D),
    .PRETRIG       (PRE),
    .AUTO_TIMEOUT  (TO),
    .HOLDOFF_FRAMES(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .trigger     (trigger),
    .frame_start (frame_start),
    .run_mode    (run_mode),
    .single_arm  (single_arm),
    .wren        (wren),
    .wraddress   (wraddress),
    .rst_trig    (rst_trig),
    .rd_base     (rd_base),
    .capture_done(capture_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive tick/frame, sample at negedge, update the address model.
  task automatic cyc();
    sample_tick = tick_ph;
    tick_ph     = ~tick_ph;
    frame_start = ((cyc_no % 7) == fr_ph);
    @(negedge clk);
    done_now = (capture_done === 1'b1);
    if (done_now) begin
      done_cnt++;
      done_cyc = cyc_no;
    end
    if (rst_trig === 1'b1) rst_trig_cnt++;
    if (wren === 1'b1) begin
      chk("wraddress", 32'(wraddress), 32'(model_ptr));
      if (prev_wa == D - 1 && int'(wraddress) == 0) wrap_seen = 1'b1;
      if (first_wa < 0) first_wa = int'(wraddress);
      prev_wa     = int'(wraddress);
      model_ptr   = (model_ptr + 1) % D;
      writes++;
      last_wr_cyc = cyc_no;
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic wait_writes(input int n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cyc();
      if (writes >= n) ok = 1'b1;
    end
    chk({tag, "_reach"}, 32'(ok), 32'd1);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int exp_w, input int exp_rd, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      cyc();
      if (done_now) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_writes"}, 32'(writes), 32'(exp_w));
      chk({tag, "_done_lat"}, 32'(last_wr_cyc), 32'(done_cyc - 1));
      chk({tag, "_rd_base"}, 32'(rd_base), 32'(exp_rd));
      cyc();
      chk({tag, "_done_1cyc"}, 32'(done_now), 32'd0);
    end
    exp_rd_last = exp_rd;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      cyc();
      if (busy === 1'b0) ok = 1'b1;
    end
    chk({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic quiet(input string tag);
    int wq;
    wq = writes;
    repeat (6) cyc();
    chk({tag, "_no_writes"}, 32'(writes), 32'(wq));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wren"}, 32'(wren), 32'd0);
    chk({tag, "_wraddress"}, 32'(wraddress), 32'd0);
    chk({tag, "_rst_trig"}, 32'(rst_trig), 32'd0);
    chk({tag, "_rd_base"}, 32'(rd_base), 32'd0);
    chk({tag, "_capture_done"}, 32'(capture_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; run_mode = 2'b11; trigger = 1'b0; single_arm = 1'b0;
    sample_tick = 1'b0; frame_start = 1'b0;
    fr_ph = $urandom_range(0, 6);
    @(posedge clk);
    #1;
    cyc();
    cyc();
    chk_reset_vals("reset");
    rst = 1'b0;
    model_ptr = 0;

    // normal mode, trigger after 7 writes
    writes = 0; rst_trig_cnt = 0; wrap_seen = 1'b0; prev_wa = -1;
    run_mode = 2'b00;
    wait_writes(7, "n1");
    pulse_trigger();
    wait_done(19, 3, "n1");
    chk("n1_rst_trig_cnt", 32'(rst_trig_cnt), 32'd1);
    chk("n1_wrap", 32'(wrap_seen), 32'd1);
    run_mode = 2'b11;
    wait_idle("n1");
    quiet("n1");

    // trigger held through pre-trigger fill
    p0 = model_ptr; writes = 0; rst_trig_cnt = 0;
    run_mode = 2'b00;
    trigger  = 1'b1;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
        cyc();
        if (rst_trig_cnt > 0) ok = 1'b1;
      end
      chk("hold_armed_entry", 32'(ok), 32'd1);
    end
    chk("hold_writes_at_arm", 32'(writes), 32'(PRE));
    trigger = 1'b0;
    wait_done(D, p0, "hold");
    chk("hold_rst_trig_cnt", 32'(rst_trig_cnt), 32'd1);
    run_mode = 2'b11;
    wait_idle("hold");

    // auto mode timeout from a fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_ptr = 0; writes = 0; rst_trig_cnt = 0;
    run_mode = 2'b01;
    wait_done(PRE + TO + (D - PRE), (PRE + TO - PRE) % D, "auto");
    run_mode = 2'b11;
    wait_idle("auto");

    // single mode: two armed captures, idle in between
    writes = 0; done_cnt = 0;
    run_mode = 2'b10;
    quiet("single_wait");
    for (int n = 0; n < 2; n++) begin
      p0 = model_ptr; writes = 0;
      single_arm = 1'b1;
      cyc();
      single_arm = 1'b0;
      k = $urandom_range(PRE, 11);
      wait_writes(k, "single");
      pulse_trigger();
      single_arm = 1'b1;
      cyc();
      single_arm = 1'b0;
      wait_done(k + D - PRE, (p0 + k - PRE + D) % D, "single");
      wait_idle("single");
      quiet("single_after");
    end
    chk("single_done_cnt", 32'(done_cnt), 32'd2);

    // stop while armed
    p0 = model_ptr; writes = 0; d0 = done_cnt;
    run_mode = 2'b00;
    wait_writes(6, "stop_armed");
    run_mode = 2'b11;
    cyc();
    chk("stop_armed_busy", 32'(busy), 32'd0);
    quiet("stop_armed");
    chk("stop_armed_rd_base", 32'(rd_base), 32'(exp_rd_last));
    chk("stop_armed_no_done", 32'(done_cnt), 32'(d0));

    // stop during capture: capture still completes
    p0 = model_ptr; writes = 0;
    run_mode = 2'b00;
    k = $urandom_range(PRE, 8);
    wait_writes(k, "stop_cap");
    pulse_trigger();
    wait_writes(k + 4, "stop_cap_mid");
    run_mode = 2'b11;
    wait_done(k + D - PRE, (p0 + k - PRE + D) % D, "stop_cap");
    wait_idle("stop_cap");
    quiet("stop_cap");

    // reset during capture, then a clean capture from address 0
    run_mode = 2'b00;
    writes = 0;
    wait_writes(6, "rst_cap");
    pulse_trigger();
    wait_writes(10, "rst_cap_mid");
    rst = 1'b1;
    cyc();
    chk_reset_vals("rst_cap");
    rst = 1'b0;
    model_ptr = 0; writes = 0; first_wa = -1;
    wait_writes(5, "rearm");
    chk("rearm_first_addr", 32'(first_wa), 32'd0);
    pulse_trigger();
    wait_done(5 + D - PRE, 1, "rearm");
    run_mode = 2'b11;
    wait_idle("rearm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
